io_uart: RTL and testbench

Serial console adapter for the basic-computer I/O path. It has two independent halves. The receive half deserialises an 8N1 line into the byte presented on the CPU's INPR input and raises FGI. The transmit half takes the OUTR byte when the CPU clears FGO, serialises it, and raises FGO again when the line is free. It sits between the datapath's datain/dataout ports and the board pins, and it owns the FGI/FGO flag state that the control unit polls and clears.

---
 rtl/io_pkg.sv | 22 ++
 rtl/io_bit_timer.sv | 46 ++++
 rtl/io_uart.sv | 242 ++++++++++++++++++++++++
 tb/tb_io_uart.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the serial console adapter.
package io_pkg;

    localparam int FRAME_DATA_BITS = 8;
    localparam int BIT_CNT_W       = $clog2(FRAME_DATA_BITS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/io_bit_timer.sv
// Bit-period timer: loaded by start (a full period, or half a period when
// half is set), then free-runs, pulsing tick once per period.
module io_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    // Counter state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Load on start; otherwise count down and reload a full period on expiry.
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = half_i ? HALF_LD : FULL_LD;
        end else if (run_q) begin
            if (cnt_q == '0) cnt_d = FULL_LD;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    assign tick_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/io_uart.sv
// 8N1 console adapter: receive half fills INPR and raises FGI, transmit half
// serialises OUTR after the CU clears FGO. The two halves share nothing.
module io_uart
    import io_pkg::*;
#(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rxd,
    output logic          txd,
    output logic [DW-1:0] inpr_data,
    output logic          fgi,
    input  logic          clr_fgi,
    input  logic [DW-1:0] outr_data,
    output logic          fgo,
    input  logic          clr_fgo,
    output logic          overrun,
    output logic          frame_err
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

    // ---------------- receive half ----------------
    logic                 rx_meta_q, rxs_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [BIT_CNT_W-1:0] rx_bit_q, rx_bit_d;
    logic [DW-1:0]        rx_sh_q, rx_sh_d;
    logic                 rx_accept_q, rx_accept_d;
    logic                 rx_tmr_start, rx_tmr_half, rx_tick;
    logic [DW-1:0]        inpr_q, inpr_d;
    logic                 fgi_q, fgi_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    io_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (rx_tmr_start),
        .half_i  (rx_tmr_half),
        .tick_o  (rx_tick)
    );

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // RX control and flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q  <= RX_IDLE;
            rx_bit_q    <= '0;
            rx_accept_q <= 1'b0;
            inpr_q      <= '0;
            fgi_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_bit_q    <= rx_bit_d;
            rx_accept_q <= rx_accept_d;
            inpr_q      <= inpr_d;
            fgi_q       <= fgi_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Receive shift register; contents only matter once a frame completes.
    always_ff @(posedge CLK) begin
        rx_sh_q <= rx_sh_d;
    end

    // RX FSM: half-bit start check, then centre sampling of data and stop bits.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_bit_d     = rx_bit_q;
        rx_sh_d      = rx_sh_q;
        rx_accept_d  = 1'b0;
        frame_err_d  = frame_err_q;
        rx_tmr_start = 1'b0;
        rx_tmr_half  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    rx_state_d   = RX_START;
                    rx_tmr_start = 1'b1;
                    rx_tmr_half  = 1'b1;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rxs_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_sh_d = {rxs_q, rx_sh_q[DW-1:1]};
                    if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_d = RX_IDLE;
                    if (rxs_q) rx_accept_d = 1'b1;
                    else       frame_err_d = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Hand a completed byte to INPR, or flag overrun if the CPU has not read the last one.
    always_comb begin
        inpr_d    = inpr_q;
        fgi_d     = fgi_q;
        overrun_d = overrun_q;
        if (rx_accept_q) begin
            if (!fgi_q || clr_fgi) begin
                inpr_d = rx_sh_q;
                fgi_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (clr_fgi) begin
            fgi_d = 1'b0;
        end
    end

    // ---------------- transmit half ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [BIT_CNT_W-1:0] tx_bit_q, tx_bit_d;
    logic [DW-1:0]        tx_sh_q, tx_sh_d;
    logic                 txd_q, txd_d;
    logic                 fgo_q, fgo_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_tmr_start, tx_tick;

    io_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (tx_tmr_start),
        .half_i  (1'b0),
        .tick_o  (tx_tick)
    );

    // TX control, line and flag registers; reset truncates any frame with a high line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q <= TX_IDLE;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
            fgo_q      <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            fgo_q      <= fgo_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Transmit shift register.
    always_ff @(posedge CLK) begin
        tx_sh_q <= tx_sh_d;
    end

    // TX FSM; txd and fgo follow the state one cycle later through their registers.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_bit_d     = tx_bit_q;
        tx_sh_d      = tx_sh_q;
        tx_done_d    = 1'b0;
        tx_tmr_start = 1'b0;
        fgo_d        = fgo_q;
        txd_d        = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                // fgo_q gate keeps the one-cycle gap before fgo rises from starting a frame.
                if (clr_fgo && fgo_q) begin
                    tx_state_d = TX_LOAD;
                    fgo_d      = 1'b0;
                end
            end
            TX_LOAD: begin
                // OUTR has settled by now (it loads on the same edge that sampled clr_fgo).
                tx_sh_d      = outr_data;
                tx_state_d   = TX_START;
                tx_tmr_start = 1'b1;
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                txd_d = tx_sh_q[0];
                if (tx_tick) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_sh_d  = {1'b0, tx_sh_q[DW-1:1]};
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_d = TX_IDLE;
                    tx_done_d  = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_done_q) fgo_d = 1'b1;
    end

    assign txd       = txd_q;
    assign fgo       = fgo_q;
    assign inpr_data = inpr_q;
    assign fgi       = fgi_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: RX vector table plus hand sequences for TX timing,
// exact RX latency, the clear/accept race, glitches, mid-frame reset and duplex.
module tb_io_uart;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rxd;
    logic       txd;
    logic [7:0] inpr_data;
    logic       fgi;
    logic       clr_fgi;
    logic [7:0] outr_data;
    logic       fgo;
    logic       clr_fgo;
    logic       overrun;
    logic       frame_err;

    int n_total = 0;
    int n_pass  = 0;

    io_uart #(.DW(8), .CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rxd       (rxd),
        .txd       (txd),
        .inpr_data (inpr_data),
        .fgi       (fgi),
        .clr_fgi   (clr_fgi),
        .outr_data (outr_data),
        .fgo       (fgo),
        .clr_fgo   (clr_fgo),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       clr;      // pulse clr_fgi before the frame
        logic [7:0] e_inpr;
        logic       e_fgi;
        logic       e_ovr;
        logic       e_ferr;
    } rx_vec_t;

    rx_vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; rxd = 1'b1; clr_fgi = 1'b0; clr_fgo = 1'b0;
        idle(2);
        RST = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int j, input logic stop);
        if (j == 0) return 1'b0;
        if (j >= 9) return stop;
        return d[j-1];
    endfunction

    function automatic logic exp_txd(input int i, input logic [7:0] b);
        if (i < 2)   return 1'b1;
        if (i < 18)  return 1'b0;
        if (i < 146) return b[(i - 18) / CPB];
        return 1'b1;
    endfunction

    // Drives one 8N1 frame; the first edge after the call samples the start fall.
    task automatic rx_frame(input logic [7:0] d, input logic stop);
        for (int j = 0; j < 10; j++) begin
            rxd = frame_bit(d, j, stop);
            repeat (CPB) @(posedge CLK);
            #1;
        end
        rxd = 1'b1;
    endtask

    // Frame plus exact-latency check: fgi low after edge 154, high after edge 155.
    task automatic rx_timed(input logic [7:0] d);
        fork
            rx_frame(d, 1'b1);
            begin
                repeat (155) @(posedge CLK);
                #1;
                chk($sformatf("rx %02h fgi before edge 155", d), fgi, 1'b0);
                @(posedge CLK);
                #1;
                chk($sformatf("rx %02h fgi at edge 155", d), fgi, 1'b1);
                chk($sformatf("rx %02h inpr at edge 155", d), inpr_data, d);
            end
        join
    endtask

    // Pulses clr_fgo (edge k) and checks the whole txd/fgo waveform through k+162.
    task automatic tx_run(input logic [7:0] b);
        int nerr;
        int first_bad;
        nerr = 0;
        first_bad = -1;
        outr_data = b;
        clr_fgo = 1'b1;
        @(posedge CLK);
        #1;
        clr_fgo = 1'b0;
        chk($sformatf("tx %02h fgo at k", b), fgo, 1'b0);
        for (int i = 1; i <= 162; i++) begin
            @(posedge CLK);
            #1;
            if (txd !== exp_txd(i, b) || fgo !== (i >= 162)) begin
                nerr++;
                if (first_bad < 0) first_bad = i;
            end
            if (i == 2)   chk($sformatf("tx %02h txd at k+2", b), txd, 1'b0);
            if (i == 161) chk($sformatf("tx %02h fgo at k+161", b), fgo, 1'b0);
            if (i == 162) chk($sformatf("tx %02h fgo at k+162", b), fgo, 1'b1);
        end
        chk($sformatf("tx %02h wave errors (first k+%0d)", b, first_bad), nerr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                data   stop  clr   inpr   fgi   ovr   ferr
        tbl[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};  // overrun
        tbl[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h5A, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1};  // bad stop bit
        tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1};

        outr_data = 8'h00;
        do_reset();
        chk("reset txd", txd, 1'b1);
        chk("reset fgo", fgo, 1'b1);
        chk("reset fgi", fgi, 1'b0);
        chk("reset inpr", inpr_data, 8'h00);
        chk("reset overrun", overrun, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);

        // TX of A5 with exact edge timing.
        idle(9);
        tx_run(8'hA5);

        // RX of 3C with exact latency.
        idle(3);
        rx_timed(8'h3C);
        idle(2);
        chk("rx 3C overrun", overrun, 1'b0);
        chk("rx 3C frame_err", frame_err, 1'b0);

        // clr_fgi on the accept cycle lets the new byte in without overrun.
        do_reset();
        rx_frame(8'h11, 1'b1);
        idle(4);
        fork
            rx_frame(8'h22, 1'b1);
            begin
                repeat (155) @(posedge CLK);
                #1;
                clr_fgi = 1'b1;
                @(posedge CLK);
                #1;
                clr_fgi = 1'b0;
            end
        join
        idle(2);
        chk("race inpr", inpr_data, 8'h22);
        chk("race fgi", fgi, 1'b1);
        chk("race overrun", overrun, 1'b0);

        // A 3-cycle low glitch is a false start.
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(60);
        chk("glitch fgi", fgi, 1'b1);
        chk("glitch inpr", inpr_data, 8'h22);
        chk("glitch frame_err", frame_err, 1'b0);

        // Sequential RX vectors (state carries row to row).
        do_reset();
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].clr) begin
                clr_fgi = 1'b1;
                idle(1);
                clr_fgi = 1'b0;
            end
            idle(2);
            rx_frame(tbl[r].data, tbl[r].stop);
            idle(30);
            chk($sformatf("tbl%0d inpr", r), inpr_data, tbl[r].e_inpr);
            chk($sformatf("tbl%0d fgi", r), fgi, tbl[r].e_fgi);
            chk($sformatf("tbl%0d overrun", r), overrun, tbl[r].e_ovr);
            chk($sformatf("tbl%0d frame_err", r), frame_err, tbl[r].e_ferr);
        end

        // Reset during TX bit 4 (byte 0F, bit4=0) and RX data bit 5.
        outr_data = 8'h0F;
        for (int c = 0; c < 97; c++) begin
            rxd = frame_bit(8'h96, c / CPB, 1'b1);
            clr_fgo = (c == 0);
            @(posedge CLK);
            #1;
        end
        clr_fgo = 1'b0;
        chk("midframe txd bit4 before reset", txd, 1'b0);
        chk("midframe fgo before reset", fgo, 1'b0);
        rxd = frame_bit(8'h96, 97 / CPB, 1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rxd = 1'b1;
        chk("midframe rst txd", txd, 1'b1);
        chk("midframe rst fgo", fgo, 1'b1);
        chk("midframe rst fgi", fgi, 1'b0);
        chk("midframe rst inpr", inpr_data, 8'h00);
        chk("midframe rst overrun", overrun, 1'b0);
        chk("midframe rst frame_err", frame_err, 1'b0);
        idle(170);
        chk("midframe dropped fgi", fgi, 1'b0);

        // Full duplex: TX FF while receiving 00.
        fork
            tx_run(8'hFF);
            rx_timed(8'h00);
        join
        idle(2);
        chk("duplex overrun", overrun, 1'b0);
        chk("duplex frame_err", frame_err, 1'b0);
        chk("duplex txd idle", txd, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
